// File: rtl/colour_seeker.sv
// colour_seeker: initiator-side controller for the dynamic LED lighting block.
// Accepts a target colour over valid/ready, then presses the lighting block's
// button one step at a time until the observed colour matches the target.
// Reports completion, the number of presses used, and error conditions
// (illegal target, illegal observed colour, timeout).

module colour_seeker #(
  parameter int unsigned MAX_STEPS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_colour,
  output logic       req_ready,
  input  logic [2:0] colour_in,
  output logic       button,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [2:0] presses
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_PRESS  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [2:0] MAX_STEPS_C = 3'(MAX_STEPS);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TARGET  = 2'b01;
  localparam logic [1:0] ERR_COLOUR  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // The lighting block only ever shows codes 001..110; 000 and 111 are illegal.
  function automatic logic colour_legal(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Lighting block sequence 001 -> ... -> 110 -> 001; kept for the checker.
  function automatic logic [2:0] colour_next(input logic [2:0] c);
    logic [2:0] n;
    if (c == 3'b110) begin
      n = 3'b001;
    end else begin
      n = c + 3'b001;
    end
    return n;
  endfunction

  state_e     state_q,     state_d;
  logic [2:0] target_q,    target_d;
  logic [2:0] presses_q,   presses_d;
  logic       button_q,    button_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;
  logic [1:0] err_code_q,  err_code_d;
  logic       req_ready_q, req_ready_d;

  // Next-state and next-output computation for the seek controller.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    presses_d  = presses_q;
    button_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone means accept.
        if (req_valid) begin
          presses_d = 3'd0;
          if (colour_legal(req_colour)) begin
            target_d = req_colour;
            state_d  = ST_SEEK;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_TARGET;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEEK: begin
        // Priority: bad observation, then match, then step budget, then press.
        if (!colour_legal(colour_in)) begin
          err_d      = 1'b1;
          err_code_d = ERR_COLOUR;
          state_d    = ST_IDLE;
        end else if (colour_in == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (presses_q == MAX_STEPS_C) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          button_d  = 1'b1;
          presses_d = presses_q + 3'd1;
          state_d   = ST_PRESS;
        end
      end

      ST_PRESS: begin
        // Button was high for exactly this cycle; release it.
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        // Give the lighting block a cycle to present its new colour.
        state_d = ST_SEEK;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // Controller state and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= 3'd0;
      presses_q   <= 3'd0;
      button_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      presses_q   <= presses_d;
      button_q    <= button_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign button    = button_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign presses   = presses_q;

  colour_seeker_chk #(
    .MAX_STEPS (MAX_STEPS)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_ready (req_ready_q),
    .button    (button_q),
    .done      (done_q),
    .err       (err_q),
    .err_code  (err_code_q),
    .presses   (presses_q),
    .colour_in (colour_in),
    .colour_nx (colour_next(colour_in))
  );

endmodule

// colour_seeker_chk: protocol properties of the seek controller outputs.
module colour_seeker_chk #(
  parameter int unsigned MAX_STEPS = 6
) (
  input logic       clk,
  input logic       rst,
  input logic       req_ready,
  input logic       button,
  input logic       done,
  input logic       err,
  input logic [1:0] err_code,
  input logic [2:0] presses,
  input logic [2:0] colour_in,
  input logic [2:0] colour_nx
);

  a_done_err_excl : assert property (@(posedge clk) disable iff (rst) !(done && err));
  a_code_idle     : assert property (@(posedge clk) disable iff (rst) !err |-> (err_code == 2'b00));
  a_code_nonzero  : assert property (@(posedge clk) disable iff (rst) err |-> (err_code != 2'b00));
  a_button_single : assert property (@(posedge clk) disable iff (rst) button |=> !button);
  a_button_busy   : assert property (@(posedge clk) disable iff (rst) button |-> !req_ready);
  a_presses_max   : assert property (@(posedge clk) disable iff (rst) presses <= 3'(MAX_STEPS));
  a_result_ready  : assert property (@(posedge clk) disable iff (rst) (done || err) |-> req_ready);
  a_colour_step   : assert property (@(posedge clk) disable iff (rst)
                                     (colour_in == 3'b110) |-> (colour_nx == 3'b001));

endmodule

// File: tb/tb_colour_seeker.sv
// Self-checking bench for colour_seeker: table of directed requests, random
// requests against a closed-form reference model, and a reset-mid-press case.

module tb_colour_seeker;

  localparam int MAX = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_colour = 3'd0;
  logic       req_ready;
  logic [2:0] colour_in;
  logic       button, done, err;
  logic [1:0] err_code;
  logic [2:0] presses;

  // Lighting block model plus fault injection on its colour output.
  logic [2:0] lb_colour = 3'd1;
  logic       lb_load = 1'b0;
  logic [2:0] lb_load_val = 3'd1;
  logic       lb_stuck = 1'b0;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'd0;

  int total = 0;
  int pass = 0;

  typedef struct {
    logic [2:0] init;
    logic [2:0] target;
    logic       stuck;
    logic       forced;
    logic [2:0] forced_val;
    int         exp_presses;
    int         exp_end;
    logic       exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t tbl[8];

  colour_seeker #(.MAX_STEPS(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_colour (req_colour),
    .req_ready  (req_ready),
    .colour_in  (colour_in),
    .button     (button),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .presses    (presses)
  );

  always #5 clk = ~clk;

  assign colour_in = force_en ? force_val : lb_colour;

  // Lighting block: advances one colour per rising edge with button high.
  always @(posedge clk) begin
    if (lb_load) lb_colour <= lb_load_val;
    else if (button && !lb_stuck) lb_colour <= (lb_colour == 3'd6) ? 3'd1 : lb_colour + 3'd1;
  end

  function automatic vec_t mk(input logic [2:0] init, input logic [2:0] target, input logic stuck,
                              input logic forced, input logic [2:0] fv, input int ep, input int ee,
                              input logic ed, input logic [1:0] ec);
    vec_t v;
    v.init = init; v.target = target; v.stuck = stuck; v.forced = forced; v.forced_val = fv;
    v.exp_presses = ep; v.exp_end = ee; v.exp_done = ed; v.exp_code = ec;
    return v;
  endfunction

  // Reference model: presses needed is the forward distance around the 6-colour ring.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int n;
    r = v;
    if (v.target == 3'd0 || v.target == 3'd7) begin
      r.exp_presses = 0; r.exp_end = 1; r.exp_done = 1'b0; r.exp_code = 2'b01;
    end else if (v.forced) begin
      r.exp_presses = 0; r.exp_end = 2; r.exp_done = 1'b0; r.exp_code = 2'b10;
    end else begin
      n = (int'(v.target) - int'(v.init) + 6) % 6;
      if (v.stuck && n != 0) n = MAX + 1;
      if (n <= MAX) begin
        r.exp_presses = n; r.exp_end = 2 + 3 * n; r.exp_done = 1'b1; r.exp_code = 2'b00;
      end else begin
        r.exp_presses = MAX; r.exp_end = 2 + 3 * MAX; r.exp_done = 1'b0; r.exp_code = 2'b11;
      end
    end
    return r;
  endfunction

  // Expected {req_ready, button, done, err, err_code, presses} in cycle c<i>.
  function automatic logic [8:0] exp_at(input vec_t v, input int i);
    int  np;
    logic rdy, btn, dn, er;
    logic [1:0] code;
    np   = (i >= 2) ? ((i - 2) / 3 + 1) : 0;
    if (np > v.exp_presses) np = v.exp_presses;
    rdy  = (i >= v.exp_end);
    btn  = (i >= 2) && (i < v.exp_end) && ((i - 2) % 3 == 0);
    dn   = (i == v.exp_end) && v.exp_done;
    er   = (i == v.exp_end) && !v.exp_done;
    code = er ? v.exp_code : 2'b00;
    return {rdy, btn, dn, er, code, 3'(np)};
  endfunction

  task automatic check(input string name, input int cyc, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s c%0d got=%b exp=%b (rdy,btn,done,err,code,presses)", name, cyc, got, exp);
  endtask

  // Load the lighting colour, issue one request, check every cycle to completion.
  task automatic run_check(input vec_t v, input string name, input logic junk);
    @(negedge clk);
    lb_load = 1'b1; lb_load_val = v.init; lb_stuck = v.stuck;
    force_en = v.forced; force_val = v.forced_val;
    @(negedge clk);
    lb_load = 1'b0;
    req_valid = 1'b1; req_colour = v.target;
    for (int i = 1; i <= v.exp_end + 1; i++) begin
      @(negedge clk);
      check(name, i, {req_ready, button, done, err, err_code, presses}, exp_at(v, i));
      if (junk && i < v.exp_end) begin
        req_valid = 1'b1; req_colour = 3'($urandom_range(0, 7));
      end else begin
        req_valid = 1'b0;
      end
    end
    force_en = 1'b0; lb_stuck = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = mk(3'd1, 3'd4, 1'b0, 1'b0, 3'd0, 3, 11, 1'b1, 2'b00);
    tbl[1] = mk(3'd2, 3'd2, 1'b0, 1'b0, 3'd0, 0,  2, 1'b1, 2'b00);
    tbl[2] = mk(3'd6, 3'd1, 1'b0, 1'b0, 3'd0, 1,  5, 1'b1, 2'b00);
    tbl[3] = mk(3'd3, 3'd7, 1'b0, 1'b0, 3'd0, 0,  1, 1'b0, 2'b01);
    tbl[4] = mk(3'd3, 3'd0, 1'b0, 1'b0, 3'd0, 0,  1, 1'b0, 2'b01);
    tbl[5] = mk(3'd2, 3'd3, 1'b1, 1'b0, 3'd0, 6, 20, 1'b0, 2'b11);
    tbl[6] = mk(3'd2, 3'd3, 1'b0, 1'b1, 3'd0, 0,  2, 1'b0, 2'b10);
    tbl[7] = mk(3'd1, 3'd6, 1'b0, 1'b0, 3'd0, 5, 17, 1'b1, 2'b00);

    // Reset state, asserted before the first clock edge.
    #3;
    check("reset_async", 0, {1'b0, button, done, err, err_code, presses}, 9'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release", 0, {req_ready, button, done, err, err_code, presses}, 9'b1_0_0_0_00_000);

    for (int k = 0; k < 8; k++) run_check(tbl[k], $sformatf("tbl%0d", k), 1'b0);

    // Reset asserted in the PRESS cycle.
    @(negedge clk);
    lb_load = 1'b1; lb_load_val = 3'd1;
    @(negedge clk);
    lb_load = 1'b0; req_valid = 1'b1; req_colour = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_press_btn", 2, {8'd0, button}, 9'd1);
    rst = 1'b1;
    #1;
    check("rst_press_clr", 2, {1'b0, button, done, err, err_code, presses}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_press_rel", 0, {req_ready, button, done, err, err_code, presses}, 9'b1_0_0_0_00_000);
    check("rst_press_lb", 0, {6'd0, lb_colour}, 9'd1);
    run_check(mk(3'd1, 3'd3, 1'b0, 1'b0, 3'd0, 2, 8, 1'b1, 2'b00), "post_rst", 1'b0);

    // Random requests against the reference model.
    for (int k = 0; k < 40; k++) begin
      v.init = 3'($urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) v.target = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
      else v.target = 3'($urandom_range(1, 6));
      v.stuck = ($urandom_range(0, 4) == 0);
      v.forced = ($urandom_range(0, 6) == 0);
      v.forced_val = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
      v = model(v);
      run_check(v, $sformatf("rand%0d", k), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
